agc_sq_rupt_ctl: RTL and testbench

- Parametrised successor to the sequence-register and interrupt-priority logic of the A3 module family.
- Holds the SQ order code and the extend bit, and owns INHINT and interrupt-in-progress (IIP).
- Latches N interrupt requests, picks the highest-priority one at each instruction boundary and forces the RUPT order code into SQ.
- Sits between the write bus (WL) and the crosspoint/time-pulse decoders.

---
 rtl/agc_sq_rupt_ctl.sv | 165 ++++++++++++++++
 tb/tb_agc_sq_rupt_ctl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/agc_sq_rupt_ctl.sv
// Sequence register (SQ, extend qualifier) with INHINT/IIP ownership and N-way interrupt priority.
// Optional IIP-stuck alarm is built when AGC_SQ_RUPT_LOCK_EN is defined.
module agc_sq_rupt_ctl #(
   parameter int              SQ_W     = 7,
   parameter int              NRUPT    = 10,
   parameter logic [SQ_W-1:0] RUPT_OP  = SQ_W'(7'h03),
   parameter int              LOCK_CYC = 140
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       gojam,
   input  logic                       wsqg,
   input  logic [SQ_W-1:0]            wl,
   input  logic                       extpls,
   input  logic                       inhpls,
   input  logic                       relpls,
   input  logic                       resume,
   input  logic                       nisq,
   input  logic [NRUPT-1:0]           rupt_req,
   output logic [SQ_W-1:0]            sq,
   output logic                       sqext,
   output logic                       inhint,
   output logic                       iip,
   output logic                       rupt_take,
   output logic [$clog2(NRUPT)-1:0]   rupt_vec,
   output logic [NRUPT-1:0]           pending,
   output logic                       rupt_lock
);

   localparam int VEC_W = $clog2(NRUPT);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TAKE   = 2'd1,
      S_INRUPT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SQ_W-1:0]  sq_q, sq_d;
   logic             sqext_q, sqext_d;
   logic             ext_pend_q, ext_pend_d;
   logic             inhint_q, inhint_d;
   logic [NRUPT-1:0] req_q;
   logic [NRUPT-1:0] pend_q, pend_d;
   logic [NRUPT-1:0] rise;
   logic [NRUPT-1:0] pend_clr;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic             take;

   // Channel 0 has the highest priority, so the lowest set index wins.
   function automatic logic [VEC_W-1:0] lowest_set(input logic [NRUPT-1:0] p);
      logic [VEC_W-1:0] idx;
      idx = '0;
      for (int i = NRUPT - 1; i >= 0; i--) begin
         if (p[i]) idx = VEC_W'(i);
      end
      return idx;
   endfunction

   always_comb begin
      rise       = rupt_req & ~req_q;
      take       = nisq && !inhint_q && (state_q == S_IDLE) && !ext_pend_q && (|pend_q);
      sq_d       = sq_q;
      sqext_d    = sqext_q;
      inhint_d   = inhint_q;
      vec_d      = vec_q;
      pend_clr   = '0;
      state_d    = state_q;
      ext_pend_d = extpls | (ext_pend_q & ~nisq);

      if (nisq)        sqext_d  = ext_pend_q;
      if (inhpls)      inhint_d = 1'b1;
      else if (relpls) inhint_d = 1'b0;
      if (wsqg)        sq_d     = wl;

      if (take) begin
         sq_d     = RUPT_OP;
         sqext_d  = 1'b0;
         vec_d    = lowest_set(pend_q);
         pend_clr = NRUPT'(1) << vec_d;
      end

      // A new rising edge on a channel being taken re-arms it (set beats clear).
      pend_d = (pend_q & ~pend_clr) | rise;

      case (state_q)
         S_IDLE:   if (take)   state_d = S_TAKE;
         S_TAKE:   state_d = resume ? S_IDLE : S_INRUPT;
         S_INRUPT: if (resume) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Async reset cannot sample the request bus, so history is forced to all ones
   // to mask any request already high; the first clock then loads the real levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sq_q       <= '0;
         sqext_q    <= 1'b0;
         ext_pend_q <= 1'b0;
         inhint_q   <= 1'b1;
         req_q      <= '1;
         pend_q     <= '0;
         vec_q      <= '0;
      end else if (gojam) begin
         state_q    <= S_IDLE;
         sq_q       <= '0;
         sqext_q    <= 1'b0;
         ext_pend_q <= 1'b0;
         inhint_q   <= 1'b1;
         req_q      <= rupt_req;
         pend_q     <= '0;
         vec_q      <= '0;
      end else begin
         state_q    <= state_d;
         sq_q       <= sq_d;
         sqext_q    <= sqext_d;
         ext_pend_q <= ext_pend_d;
         inhint_q   <= inhint_d;
         req_q      <= rupt_req;
         pend_q     <= pend_d;
         vec_q      <= vec_d;
      end
   end

   assign sq        = sq_q;
   assign sqext     = sqext_q;
   assign inhint    = inhint_q;
   assign iip       = (state_q != S_IDLE);
   assign rupt_take = (state_q == S_TAKE);
   assign rupt_vec  = vec_q;
   assign pending   = pend_q;

`ifdef AGC_SQ_RUPT_LOCK_EN
   localparam int LCNT_W = $clog2(LOCK_CYC + 1);

   logic [LCNT_W-1:0] lcnt_q;
   logic              lock_q;

   // lock_q rises at the end of the LOCK_CYC-th consecutive iip cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lcnt_q <= '0;
         lock_q <= 1'b0;
      end else if (gojam) begin
         lcnt_q <= '0;
         lock_q <= 1'b0;
      end else begin
         if (!iip)
            lcnt_q <= '0;
         else if (lcnt_q != LCNT_W'(LOCK_CYC))
            lcnt_q <= lcnt_q + 1'b1;
         if (iip && (lcnt_q == LCNT_W'(LOCK_CYC - 1)))
            lock_q <= 1'b1;
      end
   end

   assign rupt_lock = lock_q;
`else
   // Never true for a valid threshold; keeps LOCK_CYC referenced in this build.
   assign rupt_lock = (LOCK_CYC < 0);
`endif

endmodule

// File: tb/tb_agc_sq_rupt_ctl.sv
// Directed table-driven bench for agc_sq_rupt_ctl plus hand sequences for reset corners.
module tb_agc_sq_rupt_ctl;

   logic       clk;
   logic       rst;
   logic       gojam;
   logic       wsqg;
   logic [6:0] wl;
   logic       extpls;
   logic       inhpls;
   logic       relpls;
   logic       resume;
   logic       nisq;
   logic [9:0] rupt_req;
   logic [6:0] sq;
   logic       sqext;
   logic       inhint;
   logic       iip;
   logic       rupt_take;
   logic [3:0] rupt_vec;
   logic [9:0] pending;
   logic       rupt_lock;

   int checks = 0;
   int errors = 0;

   agc_sq_rupt_ctl #(
      .SQ_W(7), .NRUPT(10), .RUPT_OP(7'h03), .LOCK_CYC(8)
   ) dut (
      .clk(clk), .rst(rst), .gojam(gojam), .wsqg(wsqg), .wl(wl),
      .extpls(extpls), .inhpls(inhpls), .relpls(relpls), .resume(resume),
      .nisq(nisq), .rupt_req(rupt_req), .sq(sq), .sqext(sqext),
      .inhint(inhint), .iip(iip), .rupt_take(rupt_take), .rupt_vec(rupt_vec),
      .pending(pending), .rupt_lock(rupt_lock)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wsqg;
      logic [6:0] wl;
      logic       extpls;
      logic       inhpls;
      logic       relpls;
      logic       resume;
      logic       nisq;
      logic [9:0] req;
      logic [6:0] e_sq;
      logic       e_sqext;
      logic       e_inh;
      logic       e_iip;
      logic       e_take;
      logic [3:0] e_vec;
      logic [9:0] e_pend;
   } vec_t;

   localparam int NV = 19;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulses();
      wsqg = 0; wl = '0; extpls = 0; inhpls = 0; relpls = 0; resume = 0; nisq = 0; gojam = 0;
   endtask

   task automatic chk_all(input string tag, input logic [6:0] e_sq, input logic e_sqext,
                          input logic e_inh, input logic e_iip, input logic e_take,
                          input logic [3:0] e_vec, input logic [9:0] e_pend);
      chk({tag, ".sq"},      32'(sq),        32'(e_sq));
      chk({tag, ".sqext"},   32'(sqext),     32'(e_sqext));
      chk({tag, ".inhint"},  32'(inhint),    32'(e_inh));
      chk({tag, ".iip"},     32'(iip),       32'(e_iip));
      chk({tag, ".take"},    32'(rupt_take), 32'(e_take));
      chk({tag, ".vec"},     32'(rupt_vec),  32'(e_vec));
      chk({tag, ".pending"}, 32'(pending),   32'(e_pend));
   endtask

   initial begin
      //            wsqg wl     ext inh rel res nisq req       sq     sqx inh iip tk vec   pend
      tbl[0]  = '{1, 7'h15, 1, 0, 0, 0, 0, 10'h000, 7'h15, 0, 1, 0, 0, 4'd0, 10'h000};
      tbl[1]  = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h000, 7'h15, 1, 1, 0, 0, 4'd0, 10'h000};
      tbl[2]  = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h000, 7'h15, 0, 1, 0, 0, 4'd0, 10'h000};
      tbl[3]  = '{0, 7'h00, 0, 1, 1, 0, 0, 10'h000, 7'h15, 0, 1, 0, 0, 4'd0, 10'h000};
      tbl[4]  = '{0, 7'h00, 0, 0, 0, 0, 0, 10'h001, 7'h15, 0, 1, 0, 0, 4'd0, 10'h001};
      tbl[5]  = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h001, 7'h15, 0, 1, 0, 0, 4'd0, 10'h001};
      tbl[6]  = '{0, 7'h00, 1, 0, 1, 0, 0, 10'h001, 7'h15, 0, 0, 0, 0, 4'd0, 10'h001};
      tbl[7]  = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h001, 7'h15, 1, 0, 0, 0, 4'd0, 10'h001};
      tbl[8]  = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h001, 7'h03, 0, 0, 1, 1, 4'd0, 10'h000};
      tbl[9]  = '{0, 7'h00, 0, 0, 0, 0, 0, 10'h001, 7'h03, 0, 0, 1, 0, 4'd0, 10'h000};
      tbl[10] = '{0, 7'h00, 0, 0, 0, 1, 0, 10'h000, 7'h03, 0, 0, 0, 0, 4'd0, 10'h000};
      tbl[11] = '{0, 7'h00, 0, 0, 0, 0, 0, 10'h088, 7'h03, 0, 0, 0, 0, 4'd0, 10'h088};
      tbl[12] = '{1, 7'h11, 0, 0, 0, 0, 0, 10'h088, 7'h11, 0, 0, 0, 0, 4'd0, 10'h088};
      tbl[13] = '{1, 7'h22, 0, 0, 0, 0, 1, 10'h088, 7'h03, 0, 0, 1, 1, 4'd3, 10'h080};
      tbl[14] = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h088, 7'h03, 0, 0, 1, 0, 4'd3, 10'h080};
      tbl[15] = '{0, 7'h00, 0, 0, 0, 1, 1, 10'h088, 7'h03, 0, 0, 0, 0, 4'd3, 10'h080};
      tbl[16] = '{0, 7'h00, 0, 0, 0, 0, 1, 10'h088, 7'h03, 0, 0, 1, 1, 4'd7, 10'h000};
      tbl[17] = '{0, 7'h00, 0, 0, 0, 1, 0, 10'h088, 7'h03, 0, 0, 0, 0, 4'd7, 10'h000};
      tbl[18] = '{0, 7'h00, 0, 0, 0, 0, 0, 10'h000, 7'h03, 0, 0, 0, 0, 4'd7, 10'h000};

      rst = 1; rupt_req = '0;
      clear_pulses();
      #12;
      chk_all("reset", 7'h00, 0, 1, 0, 0, 4'd0, 10'h000);
      chk("reset.lock", 32'(rupt_lock), 32'd0);
      @(posedge clk); #1;
      rst = 0;
      tick();

      for (int i = 0; i < NV; i++) begin
         wsqg = tbl[i].wsqg; wl = tbl[i].wl; extpls = tbl[i].extpls;
         inhpls = tbl[i].inhpls; relpls = tbl[i].relpls; resume = tbl[i].resume;
         nisq = tbl[i].nisq; rupt_req = tbl[i].req;
         tick();
         chk_all($sformatf("row%0d", i), tbl[i].e_sq, tbl[i].e_sqext, tbl[i].e_inh,
                 tbl[i].e_iip, tbl[i].e_take, tbl[i].e_vec, tbl[i].e_pend);
      end
      clear_pulses();

      // gojam in the middle of an interrupt with two requests pending
      rupt_req = 10'h002; tick();
      nisq = 1; tick(); nisq = 0;
      chk_all("gj.take", 7'h03, 0, 0, 1, 1, 4'd1, 10'h000);
      rupt_req = 10'h007; tick();
      chk_all("gj.pend", 7'h03, 0, 0, 1, 0, 4'd1, 10'h005);
      gojam = 1; tick(); gojam = 0;
      chk_all("gj.clear", 7'h00, 0, 1, 0, 0, 4'd0, 10'h000);
      tick();
      chk("gj.held_req", 32'(pending), 32'h000);

      // async rst between clock edges
      relpls = 1; tick(); relpls = 0;
      rupt_req = 10'h000; tick();
      rupt_req = 10'h002; tick();
      nisq = 1; tick(); nisq = 0;
      rupt_req = 10'h007; tick();
      chk_all("ar.pend", 7'h03, 0, 0, 1, 0, 4'd1, 10'h005);
      #3; rst = 1; #1;
      chk_all("ar.clear", 7'h00, 0, 1, 0, 0, 4'd0, 10'h000);
      @(posedge clk); #1;
      rst = 0;
      tick();
      chk("ar.held_req", 32'(pending), 32'h000);

`ifdef AGC_SQ_RUPT_LOCK_EN
      relpls = 1; tick(); relpls = 0;
      rupt_req = 10'h000; tick();
      rupt_req = 10'h001; tick();
      nisq = 1; tick(); nisq = 0;
      chk("lk.take", 32'(rupt_take), 32'd1);
      for (int k = 0; k < 7; k++) tick();
      chk("lk.before", 32'(rupt_lock), 32'd0);
      tick();
      chk("lk.set", 32'(rupt_lock), 32'd1);
      resume = 1; tick(); resume = 0;
      tick();
      chk("lk.sticky", 32'(rupt_lock), 32'd1);
      chk("lk.iip", 32'(iip), 32'd0);
      #3; rst = 1; #1;
      chk("lk.rst", 32'(rupt_lock), 32'd0);
      @(posedge clk); #1;
      rst = 0;
`else
      chk("lock.off", 32'(rupt_lock), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
